chip_test_ctrl: RTL
===================

CHIP_TEST_CTRL -- requirements
Module: chip_test_ctrl

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- NUM_CHIPS, 8, number of attached chip testers.
- TIMEOUT_CYCLES, 1024, maximum cycles allowed from launch to Done.

REQ-002 Ports, one per line (name, direction, width, meaning):
- Clk, in, 1, system clock.
- Reset, in, 1, synchronous, active-high.
- Start, in, 1, raw pushbutton, asynchronous, active-high.
- Sel, in, 3, tester index from switches.
- Done_vec, in, NUM_CHIPS, Done outputs of the testers.
- RSLT_vec, in, NUM_CHIPS, RSLT outputs of the testers.
- Run_vec, out, NUM_CHIPS, one-hot Run to the testers.
- DISP_RSLT, out, 1, acknowledge to the testers, broadcast.
- Busy, out, 1, test in progress.
- Pass, out, 1, last test passed.
- Fail, out, 1, last test failed or timed out.
- Timeout, out, 1, last test timed out.
- Sel_q, out, 3, index of the last launched tester.
- Pass_cnt, out, 8, saturating pass tally.
- Fail_cnt, out, 8, saturating fail tally.

REQ-003 The block is clocked by Clk; Reset is synchronous and active-high.

Function
REQ-004 Start SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; one press SHALL produce exactly one start pulse.

REQ-005 The FSM SHALL have the states IDLE, LAUNCH, WAIT, SETTLE, ACK and HOLD.

REQ-006 State transitions SHALL be:
- IDLE/HOLD -> LAUNCH on a start pulse, latching Sel into Sel_q.
- LAUNCH -> WAIT after one cycle.
- WAIT -> SETTLE when Done_vec[Sel_q] = 1.
- WAIT -> ACK on timeout.
- SETTLE -> ACK after one cycle.
- ACK -> HOLD after one cycle.

REQ-007 In LAUNCH, Run_vec SHALL equal 1 << Sel_q for exactly one cycle; in every other state it SHALL be all zeros.

REQ-008 The timeout counter (16 bits) SHALL clear in LAUNCH and increment in each WAIT cycle; timeout occurs when the count reaches TIMEOUT_CYCLES-1 with Done_vec[Sel_q] still 0.

REQ-009 In SETTLE, RSLT_vec[Sel_q] SHALL be sampled:
- 1 sets Pass=1 and Fail=0.
- 0 sets Pass=0 and Fail=1.
SETTLE provides the one-cycle delay that lets the tester's registered RSLT update after Done.

REQ-010 On timeout, the block SHALL set Fail=1, Timeout=1 and Pass=0, then still pass through ACK.

REQ-011 DISP_RSLT SHALL be 1 only in ACK (one cycle), returning the tester to its halted state.

REQ-012 Pass_cnt or Fail_cnt SHALL increment by one at the verdict and saturate at 255.

REQ-013 Pass, Fail and Timeout SHALL clear in LAUNCH and otherwise hold until the next verdict; in HOLD they remain valid for display.

REQ-014 Busy SHALL be 1 in LAUNCH, WAIT, SETTLE and ACK.

REQ-015 Start pulses while Busy=1 SHALL be ignored and SHALL NOT be queued.

REQ-016 Changes on Sel while Busy=1 SHALL NOT affect Sel_q.

REQ-017 Done_vec bits other than bit Sel_q SHALL be ignored.

REQ-018 If Done and timeout occur in the same cycle, Done SHALL take priority.

Reset
REQ-019 Reset SHALL force:
- state IDLE, and both synchronizer flops to 0;
- Run_vec=0, DISP_RSLT=0, Busy=0;
- Pass=0, Fail=0, Timeout=0;
- Sel_q=0, Pass_cnt=0, Fail_cnt=0, timeout counter 0.

REQ-020 Reset asserted mid-test SHALL abort the test without a DISP_RSLT pulse and without a tally update.

Structure
REQ-021 Package chip_test_pkg SHALL hold the state enum, the NUM_CHIPS and TIMEOUT_CYCLES defaults, and the counter widths.

REQ-022 Sub-module start_sync_edge SHALL implement the synchronizer and edge detector of REQ-004; all other logic stays in chip_test_ctrl.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Passing tester model: Sel=3, Start pulse, model raises Done_vec[3] 5 cycles after Run_vec[3] with RSLT_vec[3]=1 -> Run_vec=8'h08 for 1 cycle, DISP_RSLT 1 cycle, Pass=1, Pass_cnt=1.
- Failing tester: Sel=0, RSLT_vec[0]=0 at Done -> Fail=1, Timeout=0, Fail_cnt=1.
- No Done: TIMEOUT_CYCLES=16, Done_vec never asserted -> Timeout=1, Fail=1, DISP_RSLT pulse, Fail_cnt increments.
- Interference: Start held high 50 cycles, plus a second press and a Sel change during WAIT -> exactly one launch, Sel_q unchanged.
- Reset mid-WAIT: Reset asserted during WAIT -> all outputs 0 next cycle, no DISP_RSLT pulse.
- Saturation: 256 passing tests -> Pass_cnt holds at 255.

Source files
------------

// File: rtl/chip_test_pkg.sv
// Shared types, defaults and helpers for the chip tester controller.
package chip_test_pkg;
  localparam int NUM_CHIPS_DEF      = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;
  localparam int TMR_W              = 16;
  localparam int CNT_W              = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    SETTLE,
    ACK,
    HOLD
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/chip_test_ctrl_if.sv
// Tester bus: one-hot Run out, Done/RSLT back, broadcast DISP_RSLT acknowledge.
interface chip_test_ctrl_if
  import chip_test_pkg::*;
#(
  parameter int NUM_CHIPS = NUM_CHIPS_DEF
);
  logic [NUM_CHIPS-1:0] Run_vec;
  logic [NUM_CHIPS-1:0] Done_vec;
  logic [NUM_CHIPS-1:0] RSLT_vec;
  logic                 DISP_RSLT;

  modport master (output Run_vec, output DISP_RSLT, input Done_vec, input RSLT_vec);
  modport slave  (input Run_vec, input DISP_RSLT, output Done_vec, output RSLT_vec);
endinterface

// File: rtl/start_sync_edge.sv
// Two-flop synchronizer for the raw Start button plus a rising-edge detector.
module start_sync_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic start_pulse
);
  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= Start;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign start_pulse = sync_p1 & ~prev_p2;
endmodule

// File: rtl/chip_test_ctrl.sv
// Launches one selected chip tester, waits for Done or timeout, latches the
// verdict and keeps saturating pass/fail tallies.
module chip_test_ctrl
  import chip_test_pkg::*;
#(
  parameter int NUM_CHIPS      = NUM_CHIPS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Sel,
  chip_test_ctrl_if.master  tst,
  output logic              Busy,
  output logic              Pass,
  output logic              Fail,
  output logic              Timeout,
  output logic [2:0]        Sel_q,
  output logic [CNT_W-1:0]  Pass_cnt,
  output logic [CNT_W-1:0]  Fail_cnt
);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             start_pulse;
  logic             done_sel;
  logic             rslt_sel;

  start_sync_edge u_sync (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .start_pulse (start_pulse)
  );

  assign done_sel = tst.Done_vec[Sel_q];
  assign rslt_sel = tst.RSLT_vec[Sel_q];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= IDLE;
      tmr           <= '0;
      tst.Run_vec   <= '0;
      tst.DISP_RSLT <= 1'b0;
      Busy          <= 1'b0;
      Pass          <= 1'b0;
      Fail          <= 1'b0;
      Timeout       <= 1'b0;
      Sel_q         <= '0;
      Pass_cnt      <= '0;
      Fail_cnt      <= '0;
    end else begin
      tst.Run_vec   <= '0;
      tst.DISP_RSLT <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (start_pulse) begin
            state       <= LAUNCH;
            Sel_q       <= Sel;
            tst.Run_vec <= NUM_CHIPS'(1) << Sel;
            Busy        <= 1'b1;
            Pass        <= 1'b0;
            Fail        <= 1'b0;
            Timeout     <= 1'b0;
            tmr         <= '0;
          end
        end
        LAUNCH: begin
          state <= WAIT;
          tmr   <= '0;
        end
        WAIT: begin
          tmr <= tmr + 1'b1;
          // Done is checked first so it wins over a timeout in the same cycle
          if (done_sel) begin
            state <= SETTLE;
          end else if (tmr == TMR_LAST) begin
            state         <= ACK;
            tst.DISP_RSLT <= 1'b1;
            Pass          <= 1'b0;
            Fail          <= 1'b1;
            Timeout       <= 1'b1;
            Fail_cnt      <= sat_inc(Fail_cnt);
          end
        end
        SETTLE: begin
          state         <= ACK;
          tst.DISP_RSLT <= 1'b1;
          Pass          <= rslt_sel;
          Fail          <= ~rslt_sel;
          if (rslt_sel) Pass_cnt <= sat_inc(Pass_cnt);
          else          Fail_cnt <= sat_inc(Fail_cnt);
        end
        ACK: begin
          state <= HOLD;
          Busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
